up_down_pulse_gen: RTL and testbench
====================================

// Module: up_down_pulse_gen
// PURPOSE
//  Command initiator for the 0-23 / 0-59 up/down time-field counters.
//  - Conditions two raw push-buttons (up, down): synchronise, debounce, then auto-repeat.
//  - Drives each counter's EN/up/down inputs with clean single-cycle step commands.
//  - Never asserts up and down together.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   consecutive cycles a synchronised input must differ before the stable value changes
//  REPEAT_DELAY     50_000_000  cycles from the first step to the first auto-repeat step while the button is held
//  REPEAT_PERIOD    10_000_000  cycles between subsequent auto-repeat steps
//  CNT_W            27          width of internal timers; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY)
// PORTS
//  clk       in   1  single system clock; all logic on posedge
//  rst       in   1  synchronous, active-high reset
//  enable    in   1  1 = adjust mode; 0 = no steps issued
//  btn_up    in   1  raw asynchronous up button, active-high
//  btn_down  in   1  raw asynchronous down button, active-high
//  EN        out  1  one-cycle step strobe to the counter
//  up        out  1  step direction up; high only in the cycle EN is high
//  down      out  1  step direction down; high only in the cycle EN is high
// BEHAVIOUR
//  Reset: EN=up=down=0; synchronisers=0; stable values=0; timers=0; state=IDLE.
//  Sync: 2-FF synchroniser per button.
//  Debounce (per button):
//   - cnt increments each cycle that sync != stable; cleared whenever sync == stable.
//   - When cnt reaches DEBOUNCE_CYCLES-1 while still differing: stable <= sync, cnt <= 0.
//  FSM states (registered outputs):
//   IDLE
//    - exactly one stable button high and enable=1 -> FIRST.
//    - both stable buttons high -> LOCK.
//   FIRST
//    - assert EN plus the matching direction for exactly 1 cycle; load timer=REPEAT_DELAY-1 -> HOLD.
//   HOLD
//    - timer decrements each cycle.
//    - at timer=0 with the same button still high -> STEP (timer=REPEAT_PERIOD-1).
//   STEP
//    - assert EN plus direction for 1 cycle -> HOLD.
//   LOCK
//    - no outputs; leave to IDLE only when both stable buttons are 0.
//  From FIRST/HOLD/STEP:
//   - active button released -> IDLE next cycle, no further step.
//   - other button also becomes high -> LOCK.
//   - enable=0 -> IDLE.
//  Latency: clean raw rise sampled at edge k -> EN high in cycle k+DEBOUNCE_CYCLES+3.
//  Glitch shorter than DEBOUNCE_CYCLES cycles: no step, stable value unchanged.
//  Held button: steps at t0, t0+REPEAT_DELAY+1, then every REPEAT_PERIOD+1 cycles.
//  Invariant: {up,down} never 2'b11; up|down implies EN; EN implies exactly one of up/down.
//  Reset mid-hold clears everything. A still-held button is re-debounced from 0,
//   giving a fresh first step DEBOUNCE_CYCLES+3 cycles after reset release.
//  Timers saturate at 0; no wrap-around.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, FIRST, HOLD, STEP, LOCK, 3 bits) and default timing constants.
//  Sub-module: debounce_sync (2-FF sync + debounce counter, params DEBOUNCE_CYCLES/CNT_W),
//   instantiated once per button. FSM and repeat timer live in this module.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  1. rst 3 cycles, then idle -> EN=up=down=0 throughout.
//  2. btn_up 1->held 10 cycles, enable=1 -> exactly one EN with up=1, 7 cycles after rise; no repeat.
//  3. btn_down held 60 cycles -> EN+down at t0, t0+21, t0+27, t0+33 ...; up never high.
//  4. btn_up glitches of 1-3 cycles -> no EN.
//  5. up held, then down pressed -> steps stop; LOCK; no EN until both released; then a fresh down press steps.
//  6. enable=0 with button held -> no EN. rst asserted mid-repeat -> outputs 0 next cycle,
//     then first step 7 cycles after rst falls.

Source files
------------

// File: rtl/up_down_pulse_gen_pkg.sv
// Shared definitions for the up/down step-command generator.
// FSM state encoding and default timing constants.
package up_down_pulse_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_HOLD  = 3'd2,
        S_STEP  = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;
    localparam int DEF_CNT_W           = 27;

endpackage

// File: rtl/up_down_pulse_gen_debounce_sync.sv
// Two-flop synchroniser followed by a consecutive-cycle debouncer.
// The stable value flips only after DEBOUNCE_CYCLES differing cycles.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_done;

    assign w_differ = r_sync[1] != r_stable;
    assign w_done   = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    assign o_stable = r_stable;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Count consecutive differing cycles; accept the new level when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_differ) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_cnt    <= '0;
            r_stable <= r_sync[1];
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/up_down_pulse_gen.sv
// Step-command generator for the hour/minute up/down counters.
// Debounced buttons drive a first step then timed auto-repeat steps.
module up_down_pulse_gen
    import up_down_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic btn_up,
    input  logic btn_down,
    output logic EN,
    output logic up,
    output logic down
);

    logic             w_up_s;
    logic             w_dn_s;
    logic             w_act;
    logic             w_oth;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dir_up;
    logic             w_dir_up_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             r_en;
    logic             r_up;
    logic             r_down;
    logic             w_en_nxt;
    logic             w_up_nxt;
    logic             w_down_nxt;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_up),
        .o_stable(w_up_s)
    );

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_down),
        .o_stable(w_dn_s)
    );

    assign w_act = r_dir_up ? w_up_s : w_dn_s;
    assign w_oth = r_dir_up ? w_dn_s : w_up_s;

    assign EN   = r_en;
    assign up   = r_up;
    assign down = r_down;

    // State, direction, repeat timer and registered step outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_dir_up <= 1'b0;
            r_timer  <= '0;
            r_en     <= 1'b0;
            r_up     <= 1'b0;
            r_down   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_timer  <= w_timer_nxt;
            r_en     <= w_en_nxt;
            r_up     <= w_up_nxt;
            r_down   <= w_down_nxt;
        end
    end

    // Next state and next step command; a step needs the button still held.
    always_comb begin
        w_state_nxt  = r_state;
        w_dir_up_nxt = r_dir_up;
        w_timer_nxt  = r_timer;
        w_en_nxt     = 1'b0;
        w_up_nxt     = 1'b0;
        w_down_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_up_s && w_dn_s) begin
                    w_state_nxt = S_LOCK;
                end else if (enable && (w_up_s ^ w_dn_s)) begin
                    w_state_nxt  = S_FIRST;
                    w_dir_up_nxt = w_up_s;
                end
            end
            S_FIRST, S_HOLD, S_STEP: begin
                if (!enable || !w_act) begin
                    w_state_nxt = S_IDLE;
                end else if (w_oth) begin
                    w_state_nxt = S_LOCK;
                end else if (r_state == S_HOLD) begin
                    if (r_timer == '0) begin
                        w_state_nxt = S_STEP;
                        w_timer_nxt = CNT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end else begin
                    w_en_nxt    = 1'b1;
                    w_up_nxt    = r_dir_up;
                    w_down_nxt  = !r_dir_up;
                    w_state_nxt = S_HOLD;
                    if (r_state == S_FIRST) begin
                        w_timer_nxt = CNT_W'(REPEAT_DELAY - 1);
                    end
                end
            end
            S_LOCK: begin
                if (!w_up_s && !w_dn_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_up_down_pulse_gen.sv
// Directed bench for up_down_pulse_gen with short timing parameters.
// Every cycle of each step is checked against hand-computed step times.
module tb_up_down_pulse_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic EN;
    logic up;
    logic down;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    up_down_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5),
        .CNT_W          (27)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .EN      (EN),
        .up      (up),
        .down    (down)
    );

    always #5 clk = ~clk;

    // Cycle c: inputs set for edge c, outputs sampled 1 time unit after it.
    // Windows are [start,end). exp_q lists cycles where a step is expected.
    task automatic run(
        input string tag,
        input int    n,
        input int    us, input int ue,
        input int    ds, input int de,
        input int    rs, input int re,
        input bit    en_in,
        input bit    dir_up
    );
        bit e_en;
        for (int c = 0; c < n; c++) begin
            btn_up   = (c >= us) && (c < ue);
            btn_down = (c >= ds) && (c < de);
            rst      = (c >= rs) && (c < re);
            enable   = en_in;
            @(posedge clk);
            #1;
            e_en = 1'b0;
            foreach (exp_q[i]) if (exp_q[i] == c) e_en = 1'b1;
            n_cmp++;
            assert (EN === e_en) else begin
                n_bad++;
                $error("FAIL %s EN c=%0d got=%b exp=%b", tag, c, EN, e_en);
            end
            n_cmp++;
            assert (up === (e_en & dir_up)) else begin
                n_bad++;
                $error("FAIL %s up c=%0d got=%b exp=%b", tag, c, up,
                       e_en & dir_up);
            end
            n_cmp++;
            assert (down === (e_en & ~dir_up)) else begin
                n_bad++;
                $error("FAIL %s down c=%0d got=%b exp=%b", tag, c, down,
                       e_en & ~dir_up);
            end
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        // reset for 3 cycles, then idle
        exp_q = {};
        run("reset_idle", 13, 0, 0, 0, 0, 0, 3, 1'b1, 1'b1);

        // short press: single up step 7 cycles after rise
        exp_q = {7};
        run("up_single", 30, 0, 10, 0, 0, 0, 0, 1'b1, 1'b1);

        // held down: first step then auto-repeat
        exp_q = {7, 28, 34, 40, 46, 52, 58, 64};
        run("down_repeat", 80, 0, 0, 0, 60, 0, 0, 1'b1, 1'b0);

        // glitches of 1..3 cycles are ignored
        exp_q = {};
        run("glitch1", 12, 0, 1, 0, 0, 0, 0, 1'b1, 1'b1);
        run("glitch2", 12, 0, 2, 0, 0, 0, 0, 1'b1, 1'b1);
        run("glitch3", 12, 0, 3, 0, 0, 0, 0, 1'b1, 1'b1);

        // up held, down joins: lock until both released
        exp_q = {7};
        run("lock", 70, 0, 40, 10, 50, 0, 0, 1'b1, 1'b1);

        // fresh down press after lock
        exp_q = {7};
        run("after_lock", 25, 0, 0, 0, 10, 0, 0, 1'b1, 1'b0);

        // enable low blocks all steps
        exp_q = {};
        run("disabled", 40, 0, 30, 0, 0, 0, 0, 1'b0, 1'b1);

        // reset where the third step would land; restart after release
        exp_q = {7, 28, 43};
        run("rst_mid", 55, 0, 0, 0, 55, 34, 36, 1'b1, 1'b0);

        exp_q = {};
        run("tail_idle", 20, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
